mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 24 ++
 rtl/mult_div_unit.sv | 128 ++++++++++++
 tb/tb_mult_div_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit:
// op codes, default latencies and FSM states.
package mult_div_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_e;

    function automatic logic md_is_long(input logic [2:0] op);
        return op <= MD_DIVU;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: behavioural arithmetic on latched
// operands, with a down-counter modelling multi-cycle latency.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    md_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] a_q, b_q;
    logic [2:0]  op_q;
    logic [31:0] hi_q, lo_q, hi_d, lo_d;
    logic        accept;

    logic [63:0] prod_s, prod_u, res;
    logic        res_ok;
    logic        a_neg, b_neg;
    logic [31:0] ua, ub, uq, ur, q, r;

    assign accept = start && (state_q == MD_IDLE) && (op <= MD_MTLO);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (accept && md_is_long(op)) begin
                a_q  <= A;
                b_q  <= B;
                op_q <= op;
            end
        end
    end

    // Sign-extended operands make the unsigned 64-bit product signed-correct.
    assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    assign prod_u = {32'b0, a_q} * {32'b0, b_q};

    // Signed divide on magnitudes avoids the INT_MIN / -1 overflow trap.
    assign a_neg = (op_q == MD_DIV) && a_q[31];
    assign b_neg = (op_q == MD_DIV) && b_q[31];
    assign ua    = a_neg ? -a_q : a_q;
    assign ub    = b_neg ? -b_q : b_q;
    assign uq    = (ub == '0) ? '0 : ua / ub;
    assign ur    = (ub == '0) ? '0 : ua % ub;
    assign q     = (a_neg ^ b_neg) ? -uq : uq;
    assign r     = a_neg ? -ur : ur;

    always_comb begin
        res    = '0;
        res_ok = 1'b1;
        unique case (op_q)
            MD_MULT:  res = prod_s;
            MD_MULTU: res = prod_u;
            MD_DIV, MD_DIVU: begin
                res    = {r, q};
                res_ok = (b_q != '0);
            end
            default:  res_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            MD_IDLE: begin
                if (accept) begin
                    if (op == MD_MTHI) begin
                        hi_d = A;
                    end else if (op == MD_MTLO) begin
                        lo_d = A;
                    end else begin
                        state_d = MD_BUSY;
                        cnt_d   = (op <= MD_MULTU) ? CW'(MULT_CYCLES)
                                                   : CW'(DIV_CYCLES);
                    end
                end
            end
            MD_BUSY: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = MD_IDLE;
                    cnt_d   = '0;
                    if (res_ok) begin
                        hi_d = res[63:32];
                        lo_d = res[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == MD_BUSY);
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed table, reset corner cases,
// and randomized ops against an arithmetic reference model.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] mh, ml;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, eh, el;
        bit          poke;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, b, oh, ol);
        longint p;
        int sa, sb;
        sa = a;
        sb = b;
        case (o)
            3'd0: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            3'd1: return {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 0) return {oh, ol};
                if (a == 32'h80000000 && b == 32'hffffffff) return {32'h0, 32'h80000000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            3'd3: begin
                if (b == 0) return {oh, ol};
                return {a % b, a / b};
            end
            3'd4: return {a, ol};
            3'd5: return {oh, a};
            default: return {oh, ol};
        endcase
    endfunction

    task automatic do_op(input string nm, input logic [2:0] o, input logic [31:0] a, b,
                         input logic [31:0] eh, el, input bit poke);
        logic [31:0] ph, pl;
        int cnt, want;
        bit stable;
        ph = hi;
        pl = lo;
        stable = 1;
        want = (o <= 3'd1) ? 5 : (o <= 3'd3) ? 10 : 0;
        start = 1; op = o; A = a; B = b;
        step();
        start = 0;
        cnt = 0;
        while (busy && cnt < 40) begin
            if (hi !== ph || lo !== pl) stable = 0;
            if (poke && cnt == 2) begin
                start = 1; op = MD_MTHI; A = 32'hdeadbeef;
            end else if (poke && cnt == 3) begin
                op = MD_MULT;
            end else begin
                start = 0; A = $urandom; B = $urandom;
            end
            cnt++;
            step();
        end
        start = 0;
        check({nm, "_cycles"}, 64'(cnt), 64'(want));
        if (want > 0) check({nm, "_hold"}, 64'(stable), 64'd1);
        check({nm, "_hi"}, 64'(hi), 64'(eh));
        check({nm, "_lo"}, 64'(lo), 64'(el));
    endtask

    initial begin
        logic [63:0] e;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        vecs[0]  = '{MD_MULT,  32'hfffffffe, 32'd3,        32'hffffffff, 32'hfffffffa, 0};
        vecs[1]  = '{MD_MULTU, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001, 0};
        vecs[2]  = '{MD_MTHI,  32'h12345678, 32'd0,        32'h12345678, 32'h00000001, 0};
        vecs[3]  = '{MD_MTLO,  32'h9abcdef0, 32'd0,        32'h12345678, 32'h9abcdef0, 0};
        vecs[4]  = '{MD_DIV,   32'hfffffff9, 32'd2,        32'hffffffff, 32'hfffffffd, 1};
        vecs[5]  = '{MD_DIV,   32'h80000000, 32'hffffffff, 32'h00000000, 32'h80000000, 0};
        vecs[6]  = '{MD_MTHI,  32'h00000011, 32'd0,        32'h00000011, 32'h80000000, 0};
        vecs[7]  = '{MD_MTLO,  32'h00000022, 32'd0,        32'h00000011, 32'h00000022, 0};
        vecs[8]  = '{MD_DIVU,  32'd7,        32'd0,        32'h00000011, 32'h00000022, 0};
        vecs[9]  = '{MD_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, 0};
        vecs[10] = '{MD_DIV,   32'd7,        32'hfffffffe, 32'h00000001, 32'hfffffffd, 0};
        vecs[11] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0};
        vecs[12] = '{3'd7,     32'h55555555, 32'd9,        32'h40000000, 32'h00000000, 0};

        reset = 1; start = 0; op = '0; A = '0; B = '0;
        step();
        step();
        reset = 0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);

        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].eh, vecs[i].el, vecs[i].poke);

        // reset in cycle 3 of a divide aborts it
        start = 1; op = MD_DIV; A = 32'd100; B = 32'd7;
        step();
        start = 0;
        step();
        step();
        check("abort_inflight", 64'(busy), 64'd1);
        reset = 1;
        step();
        reset = 0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        repeat (15) step();
        check("abort_nocommit", {31'd0, busy, hi, lo} , 64'd0);

        do_op("mthi55", MD_MTHI, 32'h55, 32'd0, 32'h55, 32'd0, 0);
        reset = 1; start = 1; op = MD_MTLO; A = 32'h77;
        step();
        reset = 0; start = 0;
        check("rst_over_start", {hi, lo}, 64'd0);
        step();
        check("rst_over_start_busy", 64'(busy), 64'd0);

        mh = 0;
        ml = 0;
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin
                ra = 32'h80000000;
                rb = 32'hffffffff;
            end
            e = model(ro, ra, rb, mh, ml);
            do_op($sformatf("rnd%0d", i), ro, ra, rb, e[63:32], e[31:0], 0);
            mh = e[63:32];
            ml = e[31:0];
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
